brick_collider: RTL and testbench

//   Per-game-tick ball/brick collision resolver, directly downstream of the game-state

---
 rtl/brick_collider_if.sv | 36 +++
 rtl/brick_collider.sv | 181 ++++++++++++++++++
 tb/tb_brick_collider.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_collider_if.sv
// Bundle between the game-state tick logic, the brick map store and the collider.
//   start / ball_*      : per-tick request and ball state (driven by the game logic)
//   busy / done         : progress and 1-cycle completion pulse
//   hit / new_dir /
//   score_inc           : tick result, held until the next start
//   brk_addr / brk_we /
//   brk_wdata           : brick map access (1-cycle read latency, write on strobe)
//   brk_rdata           : hit points of brk_addr, one cycle after the address
// The slave modport is the collider's view; the master modport is the surrounding system.
interface brick_collider_if;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] ball_vx;
  logic [9:0] ball_vy;
  logic [1:0] ball_dir;
  logic       busy;
  logic       done;
  logic       hit;
  logic [1:0] new_dir;
  logic [1:0] score_inc;
  logic [8:0] brk_addr;
  logic [2:0] brk_rdata;
  logic       brk_we;
  logic [2:0] brk_wdata;

  modport slave (
    input  start, ball_x, ball_y, ball_vx, ball_vy, ball_dir, brk_rdata,
    output busy, done, hit, new_dir, score_inc, brk_addr, brk_we, brk_wdata
  );

  modport master (
    output start, ball_x, ball_y, ball_vx, ball_vy, ball_dir, brk_rdata,
    input  busy, done, hit, new_dir, score_inc, brk_addr, brk_we, brk_wdata
  );
endinterface

// File: rtl/brick_collider.sv
// Per-game-tick ball/brick collision resolver.
// On start it probes the brick map one step ahead of the ball on the x axis, then on the
// y axis, decrements the hit points of any struck brick, reflects the direction bits and
// counts bricks taken to zero.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : brick_collider_if.slave (request, result and brick map port)
module brick_collider #(
  parameter int unsigned COLS    = 20,
  parameter int unsigned ROWS    = 24,
  parameter int unsigned BRICK_W = 32,
  parameter int unsigned BRICK_H = 10,
  parameter int unsigned BALL_R  = 4
) (
  input logic             clk,
  input logic             rst,
  brick_collider_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRdx, StEvx, StRdy, StEvy, StDone} state_e;

  localparam int unsigned ColShift = $clog2(BRICK_W);
  localparam logic [10:0] MapW     = 11'(COLS * BRICK_W);
  localparam logic [10:0] MapH     = 11'(ROWS * BRICK_H);
  localparam logic [10:0] Radius   = 11'(BALL_R);
  localparam logic [10:0] ColsW    = 11'(COLS);
  localparam logic [10:0] BrickH   = 11'(BRICK_H);

  // Returns {in_map, cell}. Probe coordinates are 11-bit two's complement, so bit 10
  // set means the probe went negative.
  function automatic logic [9:0] probe_cell(input logic [10:0] px, input logic [10:0] py);
    logic        in_map;
    logic [10:0] col;
    logic [10:0] row;
    in_map = !px[10] && !py[10] && (px < MapW) && (py < MapH);
    col    = px >> ColShift;
    row    = py / BrickH;
    probe_cell = in_map ? {1'b1, 9'(row * ColsW + col)} : 10'd0;
  endfunction

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] vy_q, vy_d;
  logic [1:0] dir_q, dir_d;
  logic       hit_q, hit_d;
  logic [1:0] score_q, score_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [8:0] addr_q, addr_d;
  logic       in_map_q, in_map_d;
  logic [8:0] x_cell_q, x_cell_d;
  logic       x_hit_q, x_hit_d;
  logic       brk_we;
  logic [2:0] brk_wdata;

  logic [10:0] x_probe_px;
  logic [10:0] y_probe_py;
  logic [9:0]  x_probe;
  logic [9:0]  y_probe;
  logic        rd_hit;

  // The x probe is formed from the raw inputs so its address is ready in RDX; only the
  // values needed later for the y probe are latched.
  assign x_probe_px = bus.ball_dir[1] ? {1'b0, bus.ball_x} + {1'b0, bus.ball_vx} + Radius
                                      : {1'b0, bus.ball_x} - {1'b0, bus.ball_vx} - Radius;
  assign y_probe_py = dir_q[0] ? {1'b0, y_q} + {1'b0, vy_q} + Radius
                               : {1'b0, y_q} - {1'b0, vy_q} - Radius;
  assign x_probe    = probe_cell(x_probe_px, {1'b0, bus.ball_y});
  assign y_probe    = probe_cell({1'b0, x_q}, y_probe_py);
  assign rd_hit     = in_map_q && (bus.brk_rdata != 3'd0);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    dir_d     = dir_q;
    hit_d     = hit_q;
    score_d   = score_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    in_map_d  = in_map_q;
    x_cell_d  = x_cell_q;
    x_hit_d   = x_hit_q;
    brk_we    = 1'b0;
    brk_wdata = 3'd0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d                = bus.ball_x;
          y_d                = bus.ball_y;
          vy_d               = bus.ball_vy;
          dir_d              = bus.ball_dir;
          hit_d              = 1'b0;
          score_d            = 2'd0;
          x_hit_d            = 1'b0;
          busy_d             = 1'b1;
          {in_map_d, addr_d} = x_probe;
          state_d            = StRdx;
        end
      end
      StRdx: state_d = StEvx;
      StEvx: begin
        if (rd_hit) begin
          brk_we    = 1'b1;
          brk_wdata = bus.brk_rdata - 3'd1;
          dir_d[1]  = ~dir_q[1];
          hit_d     = 1'b1;
          x_hit_d   = 1'b1;
          if (bus.brk_rdata == 3'd1) score_d = score_q + 2'd1;
        end
        x_cell_d           = addr_q;
        {in_map_d, addr_d} = y_probe;
        state_d            = StRdy;
      end
      StRdy: state_d = StEvy;
      StEvy: begin
        // A brick already struck by the x probe only reflects the y axis; its hit
        // points were already taken.
        if (in_map_q && x_hit_q && (addr_q == x_cell_q)) begin
          dir_d[0] = ~dir_q[0];
        end else if (rd_hit) begin
          brk_we    = 1'b1;
          brk_wdata = bus.brk_rdata - 3'd1;
          dir_d[0]  = ~dir_q[0];
          hit_d     = 1'b1;
          if (bus.brk_rdata == 3'd1) score_d = score_q + 2'd1;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      vy_q     <= '0;
      dir_q    <= '0;
      hit_q    <= 1'b0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      in_map_q <= 1'b0;
      x_cell_q <= '0;
      x_hit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      dir_q    <= dir_d;
      hit_q    <= hit_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      in_map_q <= in_map_d;
      x_cell_q <= x_cell_d;
      x_hit_q  <= x_hit_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.new_dir   = dir_q;
  assign bus.score_inc = score_q;
  assign bus.brk_addr  = addr_q;
  assign bus.brk_we    = brk_we;
  assign bus.brk_wdata = brk_wdata;

endmodule

// File: tb/tb_brick_collider.sv
// Bench for brick_collider: brick map store model, directed scenarios and randomized
// ticks checked against a behavioural model of the collision rules.
module tb_brick_collider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  brick_collider_if bif ();

  brick_collider dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Brick map store: 1-cycle read, write on strobe.
  logic [2:0] mem [480];
  logic [2:0] rdata_q = 3'd0;
  assign bif.brk_rdata = rdata_q;
  always @(posedge clk) begin
    if (bif.brk_we) mem[bif.brk_addr] <= bif.brk_wdata;
    rdata_q <= mem[bif.brk_addr];
  end

  int obs_w[$];
  always @(negedge clk) if (bif.brk_we === 1'b1) obs_w.push_back(int'(bif.brk_addr) * 8 + int'(bif.brk_wdata));

  int n_pass = 0;
  int n_total = 0;

  // Reference model state.
  int         ref_map[480];
  int         exp_w[$];
  int         exp_rdx, exp_rdy, exp_score;
  logic       exp_hit;
  logic [1:0] exp_dir;

  // Observations from do_tick.
  int         obs_lat, obs_rdx, obs_rdy, obs_extra;
  bit         obs_busy_ok;
  logic       obs_busy_done, obs_hit, obs_hit_late;
  logic [1:0] obs_dir, obs_score;

  task automatic clear_map();
    for (int i = 0; i < 480; i++) begin mem[i] = 3'd0; ref_map[i] = 0; end
  endtask

  task automatic set_cell(input int a, input int v);
    mem[a] = 3'(v);
    ref_map[a] = v;
  endtask

  function automatic int cell_of(input int px, input int py);
    if (px < 0 || px >= 640 || py < 0 || py >= 240) return -1;
    return (py / 10) * 20 + px / 32;
  endfunction

  // Rules: probe x one step ahead, then y; a struck brick loses one hit point and
  // reflects that axis; the same brick is never charged twice in one tick.
  task automatic model_tick(input int x, input int y, input int vx, input int vy,
                            input logic [1:0] dir);
    int cx, cy;
    exp_w.delete();
    exp_hit = 1'b0; exp_score = 0; exp_dir = dir;
    cx = cell_of(dir[1] ? x + vx + 4 : x - vx - 4, y);
    cy = cell_of(x, dir[0] ? y + vy + 4 : y - vy - 4);
    exp_rdx = cx; exp_rdy = cy;
    if (cx >= 0 && ref_map[cx] != 0) begin
      ref_map[cx]--;
      exp_w.push_back(cx * 8 + ref_map[cx]);
      exp_dir[1] = ~exp_dir[1]; exp_hit = 1'b1;
      if (ref_map[cx] == 0) exp_score++;
    end
    if (cy >= 0 && exp_dir[1] != dir[1] && cy == cx) begin
      exp_dir[0] = ~exp_dir[0];
    end else if (cy >= 0 && ref_map[cy] != 0) begin
      ref_map[cy]--;
      exp_w.push_back(cy * 8 + ref_map[cy]);
      exp_dir[0] = ~exp_dir[0]; exp_hit = 1'b1;
      if (ref_map[cy] == 0) exp_score++;
    end
  endtask

  function automatic bit writes_match();
    if (obs_w.size() != exp_w.size()) return 1'b0;
    foreach (obs_w[i]) if (obs_w[i] != exp_w[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int map_diff();
    for (int i = 0; i < 480; i++) if (int'(mem[i]) != ref_map[i]) return i;
    return -1;
  endfunction

  // Drives one tick and records what the DUT does; optionally re-pulses start in RDY.
  task automatic do_tick(input int x, input int y, input int vx, input int vy,
                         input logic [1:0] dir, input bit repulse);
    obs_w.delete();
    obs_lat = 0; obs_extra = 0; obs_busy_ok = 1'b1; obs_rdx = -1; obs_rdy = -1;
    @(negedge clk);
    bif.start = 1'b1; bif.ball_x = 10'(x); bif.ball_y = 10'(y);
    bif.ball_vx = 10'(vx); bif.ball_vy = 10'(vy); bif.ball_dir = dir;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) obs_rdx = int'(bif.brk_addr);
      if (n == 3) begin
        obs_rdy = int'(bif.brk_addr);
        if (repulse) begin
          bif.start = 1'b1; bif.ball_x = 10'($urandom_range(0, 639));
          bif.ball_y = 10'($urandom_range(0, 239)); bif.ball_dir = ~dir;
        end
      end
      if (n == 4) bif.start = 1'b0;
      if (n <= 4 && bif.busy !== 1'b1) obs_busy_ok = 1'b0;
      if (bif.done === 1'b1) begin
        obs_lat = n; obs_busy_done = bif.busy; obs_hit = bif.hit;
        obs_dir = bif.new_dir; obs_score = bif.score_inc;
        break;
      end
    end
    bif.start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bif.done === 1'b1) obs_extra++;
    end
    obs_hit_late = bif.hit;
  endtask

  task automatic test_reset();
    n_total++; if ({bif.busy, bif.done, bif.hit, bif.brk_we} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bif.busy, bif.done, bif.hit, bif.brk_we}); else n_pass++;
    n_total++; if ({bif.new_dir, bif.score_inc} !== 4'b0) $display("FAIL reset_dir_score: got %b want 0000", {bif.new_dir, bif.score_inc}); else n_pass++;
    n_total++; if ({bif.brk_addr, bif.brk_wdata} !== 12'b0) $display("FAIL reset_addr_wdata: got %h want 000", {bif.brk_addr, bif.brk_wdata}); else n_pass++;
  endtask

  task automatic test_empty_map();
    clear_map();
    do_tick(320, 240, 8, 6, 2'b10, 1'b0);
    n_total++; if (obs_lat !== 5) $display("FAIL empty_latency: got %0d want 5", obs_lat); else n_pass++;
    n_total++; if (obs_busy_ok !== 1'b1 || obs_busy_done !== 1'b0) $display("FAIL empty_busy: got ok=%0d at_done=%b want 1/0", obs_busy_ok, obs_busy_done); else n_pass++;
    n_total++; if (obs_hit !== 1'b0) $display("FAIL empty_hit: got %b want 0", obs_hit); else n_pass++;
    n_total++; if (obs_dir !== 2'b10) $display("FAIL empty_dir: got %b want 10", obs_dir); else n_pass++;
    n_total++; if (obs_w.size() !== 0) $display("FAIL empty_writes: got %0d want 0", obs_w.size()); else n_pass++;
  endtask

  task automatic test_single_hit();
    int w0;
    clear_map();
    set_cell(0, 1);
    do_tick(20, 14, 8, 6, 2'b00, 1'b0);
    w0 = (obs_w.size() > 0) ? obs_w[0] : -1;
    n_total++; if (obs_rdx !== 20) $display("FAIL single_rdx_addr: got %0d want 20", obs_rdx); else n_pass++;
    n_total++; if (obs_rdy !== 0) $display("FAIL single_rdy_addr: got %0d want 0", obs_rdy); else n_pass++;
    n_total++; if (obs_w.size() !== 1 || w0 !== 0) $display("FAIL single_write: got n=%0d w0=%0d want n=1 w0=0", obs_w.size(), w0); else n_pass++;
    n_total++; if ({obs_hit, obs_dir, obs_score} !== 5'b1_01_01) $display("FAIL single_result: got hit=%b dir=%b score=%0d want 1/01/1", obs_hit, obs_dir, obs_score); else n_pass++;
  endtask

  task automatic test_same_cell();
    int w0;
    clear_map();
    set_cell(0, 3);
    do_tick(30, 7, 2, 2, 2'b00, 1'b0);
    w0 = (obs_w.size() > 0) ? obs_w[0] : -1;
    n_total++; if (obs_w.size() !== 1 || w0 !== 2) $display("FAIL same_cell_write: got n=%0d w0=%0d want n=1 w0=2", obs_w.size(), w0); else n_pass++;
    n_total++; if ({obs_hit, obs_dir, obs_score} !== 5'b1_11_00) $display("FAIL same_cell_result: got hit=%b dir=%b score=%0d want 1/11/0", obs_hit, obs_dir, obs_score); else n_pass++;
  endtask

  task automatic test_out_of_map();
    clear_map();
    for (int i = 0; i < 480; i++) set_cell(i, 5);
    do_tick(5, 300, 8, 6, 2'b01, 1'b0);
    n_total++; if (obs_w.size() !== 0) $display("FAIL oom_writes: got %0d want 0", obs_w.size()); else n_pass++;
    n_total++; if ({obs_hit, obs_dir} !== 3'b0_01) $display("FAIL oom_result: got hit=%b dir=%b want 0/01", obs_hit, obs_dir); else n_pass++;
  endtask

  task automatic test_double_hit();
    int w0, w1;
    clear_map();
    set_cell(20, 1);
    set_cell(1, 1);
    do_tick(36, 14, 8, 2, 2'b00, 1'b0);
    w0 = (obs_w.size() > 0) ? obs_w[0] : -1;
    w1 = (obs_w.size() > 1) ? obs_w[1] : -1;
    n_total++; if (obs_w.size() !== 2 || w0 !== 160 || w1 !== 8) $display("FAIL double_writes: got n=%0d w0=%0d w1=%0d want 2/160/8", obs_w.size(), w0, w1); else n_pass++;
    n_total++; if ({obs_hit, obs_dir, obs_score} !== 5'b1_11_10) $display("FAIL double_result: got hit=%b dir=%b score=%0d want 1/11/2", obs_hit, obs_dir, obs_score); else n_pass++;
  endtask

  task automatic test_start_ignored();
    clear_map();
    set_cell(0, 1);
    model_tick(20, 14, 8, 6, 2'b00);
    do_tick(20, 14, 8, 6, 2'b00, 1'b1);
    n_total++; if (obs_lat !== 5) $display("FAIL repulse_latency: got %0d want 5", obs_lat); else n_pass++;
    n_total++; if (obs_extra !== 0) $display("FAIL repulse_extra_done: got %0d want 0", obs_extra); else n_pass++;
    n_total++; if ({obs_hit, obs_dir} !== {exp_hit, exp_dir}) $display("FAIL repulse_result: got %b%b want %b%b", obs_hit, obs_dir, exp_hit, exp_dir); else n_pass++;
    n_total++; if (!writes_match()) $display("FAIL repulse_writes: got n=%0d want n=%0d", obs_w.size(), exp_w.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_map();
    set_cell(20, 2);
    @(negedge clk);
    bif.start = 1'b1; bif.ball_x = 10'd12; bif.ball_y = 10'd14;
    bif.ball_vx = 10'd8; bif.ball_vy = 10'd2; bif.ball_dir = 2'b10;
    @(posedge clk);
    #1 bif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (bif.brk_we !== 1'b1) $display("FAIL midrst_we_before: got %b want 1", bif.brk_we); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bif.brk_we !== 1'b0) $display("FAIL midrst_we_drop: got %b want 0", bif.brk_we); else n_pass++;
    n_total++; if ({bif.busy, bif.done, bif.hit, bif.new_dir, bif.score_inc, bif.brk_addr} !== 16'b0) $display("FAIL midrst_outputs: got %h want 0000", {bif.busy, bif.done, bif.hit, bif.new_dir, bif.score_inc, bif.brk_addr}); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_total++; if (mem[20] !== 3'd2) $display("FAIL midrst_no_write: got %0d want 2", mem[20]); else n_pass++;
    model_tick(12, 14, 8, 2, 2'b10);
    do_tick(12, 14, 8, 2, 2'b10, 1'b0);
    n_total++; if (obs_lat !== 5) $display("FAIL midrst_after_latency: got %0d want 5", obs_lat); else n_pass++;
    n_total++; if ({obs_hit, obs_dir} !== {exp_hit, exp_dir} || !writes_match()) $display("FAIL midrst_after_result: got %b%b n=%0d want %b%b n=%0d", obs_hit, obs_dir, obs_w.size(), exp_hit, exp_dir, exp_w.size()); else n_pass++;
  endtask

  task automatic test_random();
    int x, y, vx, vy, d;
    logic [1:0] dir;
    for (int t = 0; t < 60; t++) begin
      if (t % 20 == 0) begin
        clear_map();
        for (int i = 0; i < 480; i++) if ($urandom_range(0, 1) == 1) set_cell(i, $urandom_range(1, 7));
      end
      x = $urandom_range(0, 700); y = $urandom_range(0, 300);
      vx = $urandom_range(0, 8); vy = $urandom_range(0, 8);
      dir = 2'($urandom_range(0, 3));
      model_tick(x, y, vx, vy, dir);
      do_tick(x, y, vx, vy, dir, 1'b0);
      d = map_diff();
      n_total++; if (obs_lat !== 5) $display("FAIL rnd%0d_latency: got %0d want 5", t, obs_lat); else n_pass++;
      n_total++; if ({obs_hit, obs_dir, obs_score} !== {exp_hit, exp_dir, 2'(exp_score)}) $display("FAIL rnd%0d_result: got hit=%b dir=%b score=%0d want %b/%b/%0d", t, obs_hit, obs_dir, obs_score, exp_hit, exp_dir, exp_score); else n_pass++;
      n_total++; if (!writes_match()) $display("FAIL rnd%0d_writes: got n=%0d want n=%0d", t, obs_w.size(), exp_w.size()); else n_pass++;
      if (exp_rdx >= 0) begin
        n_total++; if (obs_rdx !== exp_rdx) $display("FAIL rnd%0d_rdx_addr: got %0d want %0d", t, obs_rdx, exp_rdx); else n_pass++;
      end
      if (exp_rdy >= 0) begin
        n_total++; if (obs_rdy !== exp_rdy) $display("FAIL rnd%0d_rdy_addr: got %0d want %0d", t, obs_rdy, exp_rdy); else n_pass++;
      end
      n_total++; if (obs_extra !== 0 || obs_hit_late !== exp_hit) $display("FAIL rnd%0d_hold: got extra=%0d hit=%b want 0/%b", t, obs_extra, obs_hit_late, exp_hit); else n_pass++;
      n_total++; if (d != -1) $display("FAIL rnd%0d_map: got cell %0d=%0d want %0d", t, d, mem[d], ref_map[d]); else n_pass++;
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.ball_x = '0; bif.ball_y = '0;
    bif.ball_vx = '0; bif.ball_vy = '0; bif.ball_dir = '0;
    clear_map();
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_empty_map();
    test_single_hit();
    test_same_cell();
    test_out_of_map();
    test_double_hit();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
